// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and frame-length helpers for the UART transmitter.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    // Serial bits in one frame: start + data + optional parity + stop bits.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

    // System clock cycles taken by one frame on the line.
    function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                                 input int unsigned data_bits,
                                                 input int unsigned parity,
                                                 input int unsigned stop_bits);
        return clks_per_bit * frame_bits(data_bits, parity, stop_bits);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering words for the transmitter; read data is
// the head entry, presented combinationally.
module uart_tx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    // Qualify push/pop against full/empty and compute next pointers and count.
    always_comb begin
        push_ok = push_i && (count_q != CntW'(Depth));
        pop_ok  = pop_i && (count_q != '0);
        wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop_ok ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers; reset discards all contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; needs no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx.sv
// Parametrised UART transmitter: FIFO-buffered valid/ready input, clock-enable
// baud counter, configurable data width, parity and stop bits. Frames are sent
// back to back while words are queued.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CntW      = $clog2(CLKS_PER_BIT);
    localparam int unsigned FrameBits = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam int unsigned BitW      = $clog2(FrameBits);
    localparam int unsigned FcW       = $clog2(FIFO_DEPTH) + 1;

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx: unsupported parameter combination");
    end

    tx_state_e             state_q, state_d;
    logic [CntW-1:0]       baud_q, baud_d;
    logic [BitW-1:0]       bit_q, bit_d;      // position within frame, 0 = start bit
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  wrap, load, fifo_empty;
    logic [DATA_BITS-1:0]  fifo_rdata;

    uart_tx_fifo #(
        .Width (DATA_BITS),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid && in_ready),
        .data_i  (in_data),
        .pop_i   (load),
        .data_o  (fifo_rdata),
        .count_o (fifo_count)
    );

    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = (fifo_count != FcW'(FIFO_DEPTH));
    assign busy       = (state_q != StIdle) || !fifo_empty;
    assign tx         = tx_q;
    assign wrap       = (baud_q == CntW'(CLKS_PER_BIT - 1));

    // Next-state logic; tx_d is the line level for the bit that starts at the next edge.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        load    = 1'b0;

        if (state_q != StIdle) begin
            baud_d = wrap ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                load = !fifo_empty;
            end
            StStart: begin
                if (wrap) begin
                    state_d = StData;
                    bit_d   = bit_q + 1'b1;
                    tx_d    = shreg_q[0];
                end
            end
            StData: begin
                if (wrap) begin
                    bit_d   = bit_q + 1'b1;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BitW'(DATA_BITS)) begin
                        if (PARITY != PARITY_NONE) begin
                            state_d = StParity;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d = shreg_q[1];
                    end
                end
            end
            StParity: begin
                if (wrap) begin
                    state_d = StStop;
                    bit_d   = bit_q + 1'b1;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (wrap) begin
                    if (bit_q == BitW'(FrameBits - 1)) begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                        load    = !fifo_empty;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Popping a word starts its start bit on the same edge, so frames abut.
        if (load) begin
            shreg_d = fifo_rdata;
            par_d   = (^fifo_rdata) ^ (PARITY == PARITY_ODD);
            baud_d  = '0;
            bit_d   = '0;
            state_d = StStart;
            tx_d    = 1'b0;
        end
    end

    // FSM, baud counter, shift register and registered line output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Parametrised UART serial transmitter, successor to the fixed 8N1 free-running transmitter. It replaces the internally generated bit clock with a clock-enable baud counter on the system clock, and adds configurable data width, parity and stop bits. Input is a valid/ready byte stream buffered by a small FIFO, so back-to-back frames go out with no idle gap. It sits between the block-data producer and the off-chip serial line.

## Interface
- CLKS_PER_BIT, 10416: system clocks per serial bit (9600 baud at 100 MHz); legal ≥ 2
- DATA_BITS, 8: data bits per frame, 5–9
- PARITY, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: 1 or 2
- FIFO_DEPTH, 4: input buffer entries, power of two ≥ 2

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  DATA_BITS  word to send
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO not full; word accepted on edge where in_valid && in_ready
- tx  out  1  serial line, idle high, registered
- busy  out  1  high while a frame is in progress or FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in FIFO

## Operation
- Reset values: tx=1, busy=0, fifo_count=0, in_ready=1, FSM=IDLE, baud counter=0. Reset is asynchronous: any frame in flight is aborted, tx returns high immediately, FIFO contents discarded.
- FIFO: push on in_valid && in_ready; in_ready = (fifo_count != FIFO_DEPTH). A simultaneous push and pop leaves fifo_count unchanged. No push occurs when full; in_valid while full is held off, not dropped.
- FSM states: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE or START.
  - IDLE: tx=1. If FIFO non-empty, pop into shift register, clear baud counter, go to START.
  - START: tx=0 for one bit time.
  - DATA: DATA_BITS bits, LSB first, one bit time each.
  - PARITY: odd gives an odd total count of ones over data+parity; even gives an even total.
  - STOP: tx=1 for STOP_BITS bit times. At the end, if FIFO non-empty, pop and go directly to START (no idle cycle); else IDLE.
- Bit time: baud counter runs 0..CLKS_PER_BIT-1; bit advances when the counter wraps. Counter width is $clog2(CLKS_PER_BIT).
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles exactly.
- busy = (FSM≠IDLE) || (fifo_count≠0).
- Unsupported parameter values are an elaboration error, not clamped.

## Timing
- Word accepted into an empty FIFO with FSM idle at edge N: pop at edge N+1, tx low from edge N+1.
- tx changes only on a baud-counter wrap or the pop edge; it never glitches.
- fifo_count and in_ready reflect a pop or push on the edge after it occurs. in_ready is combinational from fifo_count only, never from in_valid.
- Frames are contiguous while data is queued: the last stop-bit period is followed immediately by the next start bit.

## Structure
- Package uart_pkg holds: parity constants PARITY_NONE/ODD/EVEN, FSM state enum, and a frame-length helper function used by bench and RTL.
- Sub-module uart_tx_fifo: synchronous FIFO (DATA_BITS wide, FIFO_DEPTH deep) with push/pop/count and the same asynchronous reset. The FSM, baud counter and shift register stay in uart_tx.

## Test plan
- Reset with in_valid=1 held → tx=1, busy=0, fifo_count=0, in_ready=1. No start bit until one edge after rst falls.
- CLKS_PER_BIT=4, 8N1, send 0xA5 → tx = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles), then busy=0.
- PARITY=2, send 0x07 → parity bit 1. PARITY=1, same data → parity bit 0. Frame is 44 cycles at CLKS_PER_BIT=4.
- FIFO_DEPTH=4, in_valid held with 6 distinct words → words 0–4 accepted on 5 consecutive edges, in_ready low from then. Word 5 is accepted the cycle after the first stop-bit end. All 6 frames go out back-to-back with no idle cycles, in order.
- Assert rst mid-DATA of first of three queued words → tx=1 in the same cycle, fifo_count=0, no further frames after release.
- DATA_BITS=7, STOP_BITS=2, PARITY=0, CLKS_PER_BIT=4, send 7'h55 → 10-bit frame (40 cycles), two stop bits high, next frame start bit at cycle 40.
